// File: rtl/decoder_scan_if.sv
// Valid/ready bus for decoder_scan: index/mode in, one-hot/index/wrap out.
// DECODER_COUNT_EN adds the beats counter output.
interface decoder_scan_if #(
    parameter int unsigned IN_W  = 3
`ifdef DECODER_COUNT_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
);
    localparam int unsigned OUT_W = 1 << IN_W;

    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in;
    logic              mode;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out;
    logic [IN_W-1:0]   idx;
    logic              wrap;
`ifdef DECODER_COUNT_EN
    logic [CNT_W-1:0]  beats;

    modport master (
        output in_valid, in, mode, out_ready,
        input  in_ready, out_valid, out, idx, wrap, beats
    );

    modport slave (
        input  in_valid, in, mode, out_ready,
        output in_ready, out_valid, out, idx, wrap, beats
    );
`else
    modport master (
        output in_valid, in, mode, out_ready,
        input  in_ready, out_valid, out, idx, wrap
    );

    modport slave (
        input  in_valid, in, mode, out_ready,
        output in_ready, out_valid, out, idx, wrap
    );
`endif
endinterface

// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with direct and scan (walking bit) modes.
// Define DECODER_COUNT_EN to add the accepted-beat counter on bus.beats.
module decoder_scan #(
    parameter int unsigned IN_W  = 3
`ifdef DECODER_COUNT_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic           clk,
    input  logic           rst,
    decoder_scan_if.slave  bus
);
    localparam int unsigned   OUT_W = 1 << IN_W;
    localparam logic [IN_W-1:0] MAX = IN_W'(OUT_W - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DIRECT = 2'd1;
    localparam logic [1:0] SCAN   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [IN_W-1:0]  idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             ready;
    logic             in_acc;
    logic             out_acc;

    // Upstream may only load when not scanning and the output slot frees up.
    assign ready   = !rst && (state_q != SCAN) && (!valid_q || bus.out_ready);
    assign in_acc  = bus.in_valid && ready;
    assign out_acc = valid_q && bus.out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        wrap_d  = wrap_q;
        case (state_q)
            IDLE, DIRECT: begin
                if (in_acc) begin
                    state_d = bus.mode ? SCAN : DIRECT;
                    out_d   = OUT_W'(1) << bus.in;
                    idx_d   = bus.in;
                    valid_d = 1'b1;
                    wrap_d  = 1'b0;
                end else if (out_acc) begin
                    state_d = IDLE;
                    out_d   = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    wrap_d  = 1'b0;
                end
            end
            SCAN: begin
                // Stop request is honoured only once the current beat is taken.
                if (out_acc) begin
                    if (!bus.mode) begin
                        state_d = IDLE;
                        out_d   = '0;
                        idx_d   = '0;
                        valid_d = 1'b0;
                        wrap_d  = 1'b0;
                    end else if (idx_q == MAX) begin
                        idx_d  = '0;
                        out_d  = OUT_W'(1);
                        wrap_d = 1'b1;
                    end else begin
                        idx_d  = idx_q + IN_W'(1);
                        out_d  = out_q << 1;
                        wrap_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = '0;
                idx_d   = '0;
                valid_d = 1'b0;
                wrap_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_q;
    assign bus.out       = out_q;
    assign bus.idx       = idx_q;
    assign bus.wrap      = wrap_q;

`ifdef DECODER_COUNT_EN
    logic [CNT_W-1:0] beats_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            beats_q <= '0;
        end else if (out_acc) begin
            beats_q <= beats_q + CNT_W'(1);
        end
    end

    assign bus.beats = beats_q;
`endif
endmodule

// File: tb/tb_decoder_scan.sv
// Directed vector bench for decoder_scan: table of per-cycle expectations plus
// scan-walk sequences with stalls (and beat counter checks under DECODER_COUNT_EN).
module tb_decoder_scan;
    localparam int unsigned IN_W  = 3;
`ifdef DECODER_COUNT_EN
    localparam int unsigned CNT_W = 16;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

`ifdef DECODER_COUNT_EN
    decoder_scan_if #(.IN_W(IN_W), .CNT_W(CNT_W)) bus ();
    decoder_scan_if #(.IN_W(IN_W), .CNT_W(4))     bus4 ();
    decoder_scan #(.IN_W(IN_W), .CNT_W(CNT_W)) dut  (.clk(clk), .rst(rst), .bus(bus));
    decoder_scan #(.IN_W(IN_W), .CNT_W(4))     dut4 (.clk(clk), .rst(rst), .bus(bus4));
    assign bus4.in_valid  = bus.in_valid;
    assign bus4.in        = bus.in;
    assign bus4.mode      = bus.mode;
    assign bus4.out_ready = bus.out_ready;
`else
    decoder_scan_if #(.IN_W(IN_W)) bus ();
    decoder_scan #(.IN_W(IN_W)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    typedef struct packed {
        logic       rst;
        logic       iv;
        logic [2:0] in;
        logic       mode;
        logic       ordy;
        logic       e_rdy;
        logic       e_val;
        logic [7:0] e_out;
        logic [2:0] e_idx;
        logic       e_wrap;
    } vec_t;

    vec_t vt [64];
    int   nv   = 0;
    int   nvec = 0;
    int   nmis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic iv, input logic [2:0] in, input logic mode,
                       input logic ordy, input logic e_rdy, input logic e_val,
                       input logic [7:0] e_out, input logic [2:0] e_idx, input logic e_wrap);
        vt[nv] = '{r, iv, in, mode, ordy, e_rdy, e_val, e_out, e_idx, e_wrap};
        nv++;
    endtask

    task automatic apply(input vec_t v, input int i);
        rst           = v.rst;
        bus.in_valid  = v.iv;
        bus.in        = v.in;
        bus.mode      = v.mode;
        bus.out_ready = v.ordy;
        @(negedge clk);
        check($sformatf("v%0d_in_ready", i),  32'(bus.in_ready),  32'(v.e_rdy));
        check($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(v.e_val));
        check($sformatf("v%0d_out", i),       32'(bus.out),       32'(v.e_out));
        check($sformatf("v%0d_idx", i),       32'(bus.idx),       32'(v.e_idx));
        check($sformatf("v%0d_wrap", i),      32'(bus.wrap),      32'(v.e_wrap));
        @(posedge clk);
        #1;
    endtask

    // Start a scan at 'start' and take n beats with periodic stalls; stop on the last beat.
    task automatic scan_walk(input logic [2:0] start, input int n);
        logic [2:0] e;
        logic       ew;
        int         done;
        int         cyc;
        rst           = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in        = start;
        bus.mode      = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("walk_start_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        e    = start;
        ew   = 1'b0;
        done = 0;
        cyc  = 0;
        while (done < n && cyc < 200) begin
            bus.out_ready = (cyc % 3 != 1);
            bus.mode      = (done < n - 1);
            @(negedge clk);
            check("walk_valid", 32'(bus.out_valid), 32'd1);
            check("walk_out",   32'(bus.out),       32'(8'(1) << e));
            check("walk_idx",   32'(bus.idx),       32'(e));
            check("walk_wrap",  32'(bus.wrap),      32'(ew));
            check("walk_ready", 32'(bus.in_ready),  32'd0);
            if (bus.out_ready) begin
                done++;
                ew = (e == 3'd7);
                e  = e + 3'd1;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        check("walk_beats_taken", 32'(done), 32'(n));
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("walk_stopped_valid", 32'(bus.out_valid), 32'd0);
        check("walk_stopped_out",   32'(bus.out),       32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset asserted with input offered: nothing may be accepted
        add(1, 1, 3'd5, 0, 1,  0, 0, 8'h00, 3'd0, 0);
        add(0, 0, 3'd0, 0, 1,  1, 0, 8'h00, 3'd0, 0);
        // back-to-back direct decodes
        add(0, 1, 3'd0, 0, 1,  1, 0, 8'h00, 3'd0, 0);
        add(0, 1, 3'd1, 0, 1,  1, 1, 8'h01, 3'd0, 0);
        add(0, 1, 3'd2, 0, 1,  1, 1, 8'h02, 3'd1, 0);
        add(0, 1, 3'd7, 0, 1,  1, 1, 8'h04, 3'd2, 0);
        add(0, 0, 3'd0, 0, 1,  1, 1, 8'h80, 3'd7, 0);
        add(0, 0, 3'd0, 0, 1,  1, 0, 8'h00, 3'd0, 0);
        // downstream stall holds the 3 decode, 6 waits
        add(0, 1, 3'd3, 0, 1,  1, 0, 8'h00, 3'd0, 0);
        for (int k = 0; k < 5; k++)
            add(0, 1, 3'd6, 0, 0,  0, 1, 8'h08, 3'd3, 0);
        add(0, 1, 3'd6, 0, 1,  1, 1, 8'h08, 3'd3, 0);
        add(0, 0, 3'd0, 0, 0,  0, 1, 8'h40, 3'd6, 0);
        add(0, 0, 3'd0, 0, 1,  1, 1, 8'h40, 3'd6, 0);
        add(0, 0, 3'd0, 0, 1,  1, 0, 8'h00, 3'd0, 0);
        // scan from 6 with wrap, stall on wrap beat, stop request during 02 beat
        add(0, 1, 3'd6, 1, 1,  1, 0, 8'h00, 3'd0, 0);
        add(0, 1, 3'd3, 1, 1,  0, 1, 8'h40, 3'd6, 0);
        add(0, 1, 3'd3, 1, 1,  0, 1, 8'h80, 3'd7, 0);
        add(0, 1, 3'd3, 0, 0,  0, 1, 8'h01, 3'd0, 1);
        add(0, 1, 3'd3, 1, 1,  0, 1, 8'h01, 3'd0, 1);
        add(0, 1, 3'd3, 0, 1,  0, 1, 8'h02, 3'd1, 0);
        add(0, 0, 3'd0, 0, 1,  1, 0, 8'h00, 3'd0, 0);
        // reset mid-scan at idx 4, then a direct decode of 2
        add(0, 1, 3'd2, 1, 1,  1, 0, 8'h00, 3'd0, 0);
        add(0, 0, 3'd0, 1, 1,  0, 1, 8'h04, 3'd2, 0);
        add(0, 0, 3'd0, 1, 1,  0, 1, 8'h08, 3'd3, 0);
        add(1, 0, 3'd0, 1, 1,  0, 1, 8'h10, 3'd4, 0);
        add(0, 1, 3'd2, 0, 1,  1, 0, 8'h00, 3'd0, 0);
        add(0, 0, 3'd0, 0, 1,  1, 1, 8'h04, 3'd2, 0);
        add(0, 0, 3'd0, 0, 1,  1, 0, 8'h00, 3'd0, 0);

        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in        = 3'd5;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < nv; i++)
            apply(vt[i], i);

        scan_walk(3'd0, 9);

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        scan_walk(3'd5, 10);
`ifdef DECODER_COUNT_EN
        check("beats_after_10",    32'(bus.beats),  32'd10);
        check("beats4_after_10",   32'(bus4.beats), 32'd10);
`endif
        scan_walk(3'd1, 7);
`ifdef DECODER_COUNT_EN
        check("beats_after_17",    32'(bus.beats),  32'd17);
        check("beats4_after_17",   32'(bus4.beats), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
